// File: rtl/d8_pkg.sv
// Shared definitions for the d8 load/writeback slice: opcodes, FSM state
// type and default datapath width.
package d8_pkg;

    localparam int          D8_DW_DEFAULT = 8;
    localparam logic [7:0]  D8_OP_LOAD    = 8'h07;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } d8_load_state_t;

endpackage : d8_pkg

// File: rtl/d8_wait_timer.sv
// Wait-cycle counter for the load unit. Cleared while idle, advances once per
// enabled cycle, and flags done on the enabled cycle that reaches LIMIT.
module d8_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic done
);
    logic [7:0] count_reg;

    // done fires on the LIMIT-th enabled cycle, so an ack in that same cycle
    // can still take priority in the caller.
    assign done = enable && (count_reg == 8'(LIMIT - 1));

    // Count enabled cycles since the last clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && !done) begin
            count_reg <= count_reg + 8'd1;
        end
    end

endmodule : d8_wait_timer

// File: rtl/d8_load_wb.sv
// d8 load/writeback unit. Non-load ops write B-operand data back one cycle
// after issue; loads run a req/ack handshake and write back the memory data.
// Optional feature macro: D8_LOAD_TIMEOUT_EN (abandons a load after
// TO_CYCLES unacknowledged wait cycles and pulses err).
module d8_load_wb
    import d8_pkg::*;
#(
    parameter int         DW        = D8_DW_DEFAULT,
    parameter int         NREG      = 4,
    parameter logic [7:0] OP_LOAD   = D8_OP_LOAD,
    parameter int         TO_CYCLES = 16,
    localparam int        RW        = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          issue,
    input  logic [7:0]    op,
    input  logic [DW-1:0] b_in,
    input  logic [RW-1:0] dst,
    output logic          mem_req,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_dout,
    output logic          busy,
    output logic          wb_valid,
    output logic [DW-1:0] wb_data,
    output logic [RW-1:0] wb_dst,
    output logic          err
);
    d8_load_state_t state_reg;
    logic [RW-1:0]  dst_latch_reg;
    logic           timeout;

    assign busy = (state_reg == WAIT);

`ifdef D8_LOAD_TIMEOUT_EN
    // Timer only counts WAIT cycles that saw no ack; it sits cleared in IDLE,
    // which also clears it on every entry to WAIT.
    d8_wait_timer #(
        .LIMIT (TO_CYCLES)
    ) u_wait_timer (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .clear  (state_reg == IDLE),
        .enable ((state_reg == WAIT) && !mem_ack),
        .done   (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // Load/writeback sequencer with registered outputs; strobes default low.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg     <= IDLE;
            mem_req       <= 1'b0;
            wb_valid      <= 1'b0;
            wb_data       <= '0;
            wb_dst        <= '0;
            err           <= 1'b0;
            dst_latch_reg <= '0;
        end else begin
            wb_valid <= 1'b0;
            err      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // Acks arriving here (late or spurious) are ignored.
                    if (issue) begin
                        if (op == OP_LOAD) begin
                            dst_latch_reg <= dst;
                            mem_req       <= 1'b1;
                            state_reg     <= WAIT;
                        end else begin
                            wb_valid <= 1'b1;
                            wb_data  <= b_in;
                            wb_dst   <= dst;
                        end
                    end
                end
                WAIT: begin
                    // Issue is ignored here; an ack beats a same-cycle timeout.
                    if (mem_ack) begin
                        wb_valid  <= 1'b1;
                        wb_data   <= mem_dout;
                        wb_dst    <= dst_latch_reg;
                        mem_req   <= 1'b0;
                        state_reg <= IDLE;
                    end else if (timeout) begin
                        mem_req   <= 1'b0;
                        err       <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    mem_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule : d8_load_wb

// File: tb/tb_d8_load_wb.sv
// Directed testbench for d8_load_wb (default parameters). Timeout scenarios
// are included when D8_LOAD_TIMEOUT_EN is defined.
module tb_d8_load_wb;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       issue = 1'b0;
    logic [7:0] op = 8'h00;
    logic [7:0] b_in = 8'h00;
    logic [1:0] dst = 2'd0;
    logic       mem_req;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_dout = 8'h00;
    logic       busy;
    logic       wb_valid;
    logic [7:0] wb_data;
    logic [1:0] wb_dst;
    logic       err;

    int checks = 0;
    int errors = 0;

    d8_load_wb #(
        .DW        (8),
        .NREG      (4),
        .OP_LOAD   (8'h07),
        .TO_CYCLES (16)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .issue     (issue),
        .op        (op),
        .b_in      (b_in),
        .dst       (dst),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .mem_dout  (mem_dout),
        .busy      (busy),
        .wb_valid  (wb_valid),
        .wb_data   (wb_data),
        .wb_dst    (wb_dst),
        .err       (err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit past the next rising edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check_wb(input string tag, input logic v, input logic [7:0] d, input logic [1:0] r);
        check({tag, ".wb_valid"}, 32'(wb_valid), 32'(v));
        check({tag, ".wb_data"},  32'(wb_data),  32'(d));
        check({tag, ".wb_dst"},   32'(wb_dst),   32'(r));
    endtask

    initial begin
        // Reset state
        #2;
        check("rst.mem_req", 32'(mem_req), 32'd0);
        check("rst.busy",    32'(busy),    32'd0);
        check("rst.err",     32'(err),     32'd0);
        check_wb("rst", 1'b0, 8'h00, 2'd0);
        #10 sys_rst_n = 1'b1;
        tick();

        // Non-load: one-cycle writeback of b_in
        issue = 1'b1; op = 8'h01; b_in = 8'hA5; dst = 2'd2;
        tick();
        check_wb("alu", 1'b1, 8'hA5, 2'd2);
        check("alu.mem_req", 32'(mem_req), 32'd0);
        issue = 1'b0;
        tick();
        check_wb("alu_hold", 1'b0, 8'hA5, 2'd2);
        $display("txn alu op=01 b=A5 dst=2 -> wb=%0h dst=%0d", wb_data, wb_dst);

        // Load, acked on the 3rd WAIT cycle, with an ignored issue in WAIT
        issue = 1'b1; op = 8'h07; dst = 2'd3;
        tick();
        check("ld.w1.mem_req", 32'(mem_req), 32'd1);
        check("ld.w1.busy",    32'(busy),    32'd1);
        issue = 1'b1; op = 8'h01; b_in = 8'hFF; dst = 2'd0;
        tick();
        check("ld.w2.mem_req", 32'(mem_req), 32'd1);
        check("ld.w2.busy",    32'(busy),    32'd1);
        check("ld.w2.wb_valid", 32'(wb_valid), 32'd0);
        issue = 1'b0;
        tick();
        check("ld.w3.mem_req", 32'(mem_req), 32'd1);
        check("ld.w3.busy",    32'(busy),    32'd1);
        check("ld.w3.wb_valid", 32'(wb_valid), 32'd0);
        mem_ack = 1'b1; mem_dout = 8'h3C;
        tick();
        check_wb("ld", 1'b1, 8'h3C, 2'd3);
        check("ld.mem_req", 32'(mem_req), 32'd0);
        check("ld.busy",    32'(busy),    32'd0);
        $display("txn load dst=3 ack@w3 data=3C -> wb=%0h dst=%0d", wb_data, wb_dst);

        // Back-to-back issue during the load's writeback cycle
        mem_ack = 1'b0;
        issue = 1'b1; op = 8'h02; b_in = 8'h11; dst = 2'd1;
        tick();
        check_wb("b2b", 1'b1, 8'h11, 2'd1);
        $display("txn b2b op=02 b=11 dst=1 -> wb=%0h dst=%0d", wb_data, wb_dst);

        // Spurious ack while IDLE
        issue = 1'b0; mem_ack = 1'b1; mem_dout = 8'h77;
        tick();
        check_wb("idle_ack", 1'b0, 8'h11, 2'd1);
        check("idle_ack.busy", 32'(busy), 32'd0);
        mem_ack = 1'b0;
        $display("txn idle ack data=77 -> wb_valid=%0d", wb_valid);

        // Minimum latency load: ack in the first WAIT cycle
        issue = 1'b1; op = 8'h07; dst = 2'd1;
        tick();
        issue = 1'b0; mem_ack = 1'b1; mem_dout = 8'hC3;
        tick();
        check_wb("ld_min", 1'b1, 8'hC3, 2'd1);
        mem_ack = 1'b0;
        $display("txn load dst=1 ack@w1 data=C3 -> wb=%0h dst=%0d", wb_data, wb_dst);

        // Reset asserted mid-load
        issue = 1'b1; op = 8'h07; dst = 2'd2;
        tick();
        issue = 1'b0;
        check("rstmid.busy_before", 32'(busy), 32'd1);
        #2 sys_rst_n = 1'b0;
        #1;
        check("rstmid.mem_req", 32'(mem_req), 32'd0);
        check("rstmid.busy",    32'(busy),    32'd0);
        tick();
        sys_rst_n = 1'b1; mem_ack = 1'b1; mem_dout = 8'h55;
        tick();
        check_wb("rstmid_ack", 1'b0, 8'h00, 2'd0);
        check("rstmid_ack.busy", 32'(busy), 32'd0);
        mem_ack = 1'b0;
        $display("txn reset mid-load, late ack data=55 -> wb_valid=%0d", wb_valid);

`ifdef D8_LOAD_TIMEOUT_EN
        // Timeout: 16 WAIT cycles without ack
        issue = 1'b1; op = 8'h07; dst = 2'd3;
        tick();
        issue = 1'b0;
        for (int i = 1; i < 16; i++) begin
            check("to.mem_req_wait", 32'(mem_req), 32'd1);
            check("to.err_wait",     32'(err),     32'd0);
            tick();
        end
        check("to.w16.busy", 32'(busy), 32'd1);
        tick();
        check("to.err",      32'(err),      32'd1);
        check("to.mem_req",  32'(mem_req),  32'd0);
        check("to.wb_valid", 32'(wb_valid), 32'd0);
        check("to.busy",     32'(busy),     32'd0);
        mem_ack = 1'b1; mem_dout = 8'h9A;
        tick();
        check("to_late.err",      32'(err),      32'd0);
        check("to_late.wb_valid", 32'(wb_valid), 32'd0);
        mem_ack = 1'b0;
        $display("txn load dst=3 no ack -> timeout err pulse");

        // Ack on the limit cycle wins over the timeout
        issue = 1'b1; op = 8'h07; dst = 2'd2;
        tick();
        issue = 1'b0;
        for (int i = 1; i < 16; i++) tick();
        mem_ack = 1'b1; mem_dout = 8'h6B;
        tick();
        check_wb("to_ack", 1'b1, 8'h6B, 2'd2);
        check("to_ack.err", 32'(err), 32'd0);
        mem_ack = 1'b0;
        $display("txn load dst=2 ack@w16 data=6B -> wb=%0h err=%0d", wb_data, err);
`else
        // Without the timeout feature a long wait never raises err
        issue = 1'b1; op = 8'h07; dst = 2'd3;
        tick();
        issue = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("nto.busy",    32'(busy),    32'd1);
        check("nto.mem_req", 32'(mem_req), 32'd1);
        check("nto.err",     32'(err),     32'd0);
        mem_ack = 1'b1; mem_dout = 8'h9A;
        tick();
        check_wb("nto_ack", 1'b1, 8'h9A, 2'd3);
        mem_ack = 1'b0;
        $display("txn load dst=3 ack@w21 data=9A -> wb=%0h dst=%0d", wb_data, wb_dst);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_d8_load_wb
